// File: rtl/mem_stream_loader_pkg.sv
// rtl/mem_stream_loader_pkg.sv - shared widths and FSM encoding for the stream loader
package mem_stream_loader_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/out_reg_slice.sv
// rtl/out_reg_slice.sv - one-entry valid/ready register slice feeding the dump stream
module out_reg_slice #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Refill in the same cycle the held word is taken, so a steady consumer sees no bubbles.
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/mem_stream_loader.sv
// rtl/mem_stream_loader.sv - moves a word stream into memory (load) or memory out to a stream (dump)
module mem_stream_loader
  import mem_stream_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start_load,
  input  logic              i_start_dump,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_count,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic [ADDR_W-1:0] o_mem_index,
  output logic              o_mem_wr,
  output logic [DATA_W-1:0] o_mem_in,
  input  logic [DATA_W-1:0] i_mem_out,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_busy;
  logic              r_done;
  logic              r_s_ready;

  logic              w_wr;
  logic              w_push;
  logic              w_push_ready;
  logic              w_pop;
  logic              w_m_valid;

  // The memory read is combinational, so a load write and a dump fetch both use ptr directly.
  assign w_wr   = (r_state == ST_LOAD) && i_s_valid;
  assign w_push = (r_state == ST_DUMP) && (r_remaining != '0);
  assign w_pop  = w_m_valid && i_m_ready;

  assign o_mem_index = r_ptr;
  assign o_mem_wr    = w_wr;
  assign o_mem_in    = w_wr ? i_s_data : '0;
  assign o_s_ready   = r_s_ready;
  assign o_m_valid   = w_m_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

  out_reg_slice #(
    .DATA_W(DATA_W)
  ) u_out_reg_slice (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(w_push),
    .o_ready(w_push_ready),
    .i_data (i_mem_out),
    .o_valid(w_m_valid),
    .i_ready(i_m_ready),
    .o_data (o_m_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_s_ready   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start_load || i_start_dump) begin
            r_ptr       <= i_base;
            r_remaining <= i_count;
            r_busy      <= 1'b1;
            if (i_count == '0) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else if (i_start_load) begin
              r_state   <= ST_LOAD;
              r_s_ready <= 1'b1;
            end else begin
              r_state <= ST_DUMP;
            end
          end
        end
        ST_LOAD: begin
          if (w_wr) begin
            r_ptr       <= r_ptr + 1'b1;
            r_remaining <= r_remaining - ONE;
            if (r_remaining == ONE) begin
              r_state   <= ST_FIN;
              r_done    <= 1'b1;
              r_s_ready <= 1'b0;
            end
          end
        end
        ST_DUMP: begin
          if (w_push && w_push_ready) begin
            r_ptr       <= r_ptr + 1'b1;
            r_remaining <= r_remaining - ONE;
          end
          // Every word has been fetched; finish once the last one is taken downstream.
          if ((r_remaining == '0) && w_pop) begin
            r_state <= ST_FIN;
            r_done  <= 1'b1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
